// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a choice of registered or fall-through read.
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic             deq,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW + 1)'(AF_THRESH);
    localparam logic [AW:0] AE_C    = (AW + 1)'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;
    logic          wr_ok, rd_ok;

    // Status flags decode the registered count, so they reflect pre-edge state.
    assign full         = (count_reg == DEPTH_C);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_C);
    assign almost_empty = (count_reg <= AE_C);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    assign wr_ok = enq && !full;
    assign rd_ok = deq && !empty;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        if (wr_ok) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count_reg + (AW + 1)'(1);
            2'b01:   count_next = count_reg - (AW + 1)'(1);
            default: count_next = count_reg;
        endcase
        // A new error event outranks a clear in the same cycle.
        overflow_next  = (overflow_reg && !clr_err) || (enq && full);
        underflow_next = (underflow_reg && !clr_err) || (deq && empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage is never reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = empty ? '0 : mem[rd_ptr_reg];
        end else begin : g_registered
            logic [WIDTH-1:0] dout_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_reg <= '0;
                end else if (rd_ok) begin
                    dout_reg <= mem[rd_ptr_reg];
                end
            end

            assign dout = dout_reg;
        end
    endgenerate

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parameterised single-clock synchronous FIFO. It is the next-generation buffering primitive for the datapath, generalised in data width and depth. Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable read mode (registered or first-word-fall-through). It sits between any producer/consumer pair sharing one clock.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AW, $clog2(DEPTH), pointer width (derived; not overridden)
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
enq  input  1  write request
deq  input  1  read request
din  input  WIDTH  write data
clr_err  input  1  clears sticky overflow/underflow
dout  output  WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  AW+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: enq attempted while full
underflow  output  1  sticky: deq attempted while empty

Behaviour:
- Reset (rst=1 at a clock edge): wr_ptr=0, rd_ptr=0, count=0, dout=0, overflow=0, underflow=0. Therefore empty=1, full=0, almost_empty=1, and almost_full=0 (given AF_THRESH>=1). Memory contents are not cleared. Reset takes priority over all other inputs. Reset mid-operation discards all stored data.
- Write accepted (wr_ok) iff enq && !full. It stores din at mem[wr_ptr] and advances wr_ptr modulo DEPTH (natural AW-bit wrap).
- Read accepted (rd_ok) iff deq && !empty. It advances rd_ptr modulo DEPTH.
- Full/empty gating uses the pre-edge state. An enq while full is rejected even if deq is accepted in the same cycle. A deq while empty is rejected even if enq is accepted in the same cycle.
- Count update per cycle: +1 if wr_ok && !rd_ok; -1 if rd_ok && !wr_ok; otherwise unchanged. Simultaneous accepted write and read leaves count unchanged, and both pointers advance.
- full, empty, almost_full, almost_empty: combinational decodes of the registered count. No extra latency.
- FWFT=0:
  - On rd_ok, dout is registered with mem[rd_ptr] and is valid the cycle after the deq edge (1-cycle latency).
  - dout holds its value when there is no rd_ok.
- FWFT=1:
  - dout = mem[rd_ptr] combinationally whenever !empty, and 0 when empty.
  - Data written into an empty FIFO appears on dout in the cycle after the write edge.
  - deq acknowledges the displayed word; the next word is shown after the edge.
- Sticky error flags:
  - overflow sets at an edge where enq && full; underflow sets at an edge where deq && empty.
  - Both hold until clr_err or rst. If set and clr_err occur in the same cycle, set wins.
  - Rejected requests do not change pointers, count or memory.
- Pointer wrap: after DEPTH accepted writes, wr_ptr returns to 0. Ordering is preserved across the wrap.

Test Plan:
- Reset: assert rst for 2 cycles with enq=1 -> count=0, empty=1, full=0, almost_empty=1, overflow=0, underflow=0, dout=0.
- Fill/drain, WIDTH=8, DEPTH=16, FWFT=0: write 0x00..0x0F -> full=1 after 16th edge, almost_full=1 at count 14. Read 16 -> dout sequence 0x00..0x0F, each one cycle after its deq, then empty=1.
- Overflow/underflow: on full FIFO, enq=1 din=0xAA with deq=1 -> one read accepted, write rejected, count=15, overflow=1. Drain, then deq on empty -> underflow=1, count stays 0. Pulse clr_err -> both 0.
- Simultaneous ops at count=5: enq=deq=1 for 20 cycles -> count stays 5, pointers wrap past 15 to 0, data order preserved.
- FWFT=1: write 0x5A into empty -> dout=0x5A the next cycle with no deq. Then deq -> empty=1 and dout=0.
- Reset mid-operation at count=9 -> count=0, empty=1, and the next write/read returns the new data, not stale data.
